// File: rtl/inst_sram_resp.sv
// Purpose: instruction SRAM responder, byte-lane writes, out-of-window err, saturating rd/wr counters.
// Latency: 1 cycle (request at edge N, rdata/err valid after edge N+1).
// Backpressure: none; every request with sram_en high is accepted each cycle.
module inst_sram_resp #(
    parameter logic [31:0] ADDR_BASE  = 32'h1c000000,
    parameter int          DEPTH_LOG2 = 14,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        sram_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    // Window size in bytes, one bit wider so a 4 GiB window cannot overflow.
    localparam logic [32:0] WIN_BYTES = 33'd4 << DEPTH_LOG2;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]           off;
    logic                  in_win;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  is_rd;
    logic                  is_wr;
    logic                  mem_we;

    logic [31:0] rdata_d, rdata_q;
    logic        err_d, err_q;
    logic [31:0] rd_cnt_d, rd_cnt_q;
    logic [31:0] wr_cnt_d, wr_cnt_q;

    always_comb begin
        off    = sram_addr - ADDR_BASE;
        // The lower-bound test catches addresses below the base whose wrapped
        // offset would otherwise look small enough to be in window.
        in_win = (sram_addr >= ADDR_BASE) && ({1'b0, off} < WIN_BYTES);
        idx    = off[DEPTH_LOG2+1:2];
        is_rd  = sram_en && (sram_wen == 4'h0);
        is_wr  = sram_en && (sram_wen != 4'h0);
        mem_we = is_wr && in_win;

        // Response holds across idle cycles; reads and writes alike return the
        // current (pre-write) word, or zero with err when out of window.
        rdata_d = rdata_q;
        err_d   = err_q;
        if (sram_en) begin
            rdata_d = in_win ? mem_q[idx] : 32'h0;
            err_d   = !in_win;
        end

        rd_cnt_d = rd_cnt_q;
        if (is_rd && (rd_cnt_q != 32'hffffffff)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        wr_cnt_d = wr_cnt_q;
        if (is_wr && (wr_cnt_q != 32'hffffffff)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    // The array shares the reset domain only to suppress writes while resetn
    // is low; its contents are deliberately left untouched by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            rd_cnt_q <= 32'h0;
            wr_cnt_q <= 32'h0;
        end else begin
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            for (int i = 0; i < 4; i++) begin
                if (mem_we && sram_wen[i]) begin
                    mem_q[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    assign sram_rdata = rdata_q;
    assign sram_err   = err_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
module tb_inst_sram_resp;

  localparam logic [31:0] BASE  = 32'h1c000000;
  localparam int          DLOG2 = 14;
  localparam longint      WIN   = longint'(4) << DLOG2;
  localparam logic [31:0] LAST  = BASE + 32'(WIN) - 32'd4;

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  inst_sram_resp #(
    .ADDR_BASE (BASE),
    .DEPTH_LOG2(DLOG2),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sram_en   (sram_en),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_err  (sram_err),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] rd;
    logic [31:0] wr;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [31:0] mem_m [int];   // reference memory keyed by word index
  logic [31:0] m_rd = 0;
  logic [31:0] m_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: issue one request at a falling edge and predict the
  // response that appears after the following rising edge.
  task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off, mask, old;
    bit          inw;
    int          idx;
    exp_t        e;
    @(negedge clk);
    sram_en = 1'b1; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    if (!resetn) return;
    off = addr - BASE;
    inw = (addr >= BASE) && (longint'(off) < WIN);
    idx = int'(off / 4);
    old = (inw && mem_m.exists(idx)) ? mem_m[idx] : 32'h0;
    e.err   = !inw;
    e.rdata = inw ? old : 32'h0;
    if (wen == 4'h0) begin
      if (m_rd != 32'hffffffff) m_rd = m_rd + 1;
    end else begin
      if (m_wr != 32'hffffffff) m_wr = m_wr + 1;
      if (inw) begin
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (wen[b]) mask = mask | (32'hff << (8 * b));
        mem_m[idx] = (old & ~mask) | (wdata & mask);
      end
    end
    e.rd = m_rd;
    e.wr = m_wr;
    exp_q.push_back(e);
  endtask

  // Idle cycle with garbage on the other request lines.
  task automatic idle();
    @(negedge clk);
    sram_en = 1'b0; sram_wen = 4'($urandom);
    sram_addr = $urandom; sram_wdata = $urandom;
  endtask

  task automatic assert_rst();
    resetn = 1'b0;
    exp_q.delete();
    m_rd = 0;
    m_wr = 0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    sram_en = 1'b0;
    resetn  = 1'b1;
  endtask

  // Monitor: each rising edge either produces the next queued response or
  // (idle / reset) the held or zeroed one; all four outputs checked each cycle.
  exp_t cur = '0;
  always @(posedge clk) begin
    logic fired;
    fired = sram_en && resetn;
    #1;
    if (!resetn) begin
      cur = '0;
    end else if (fired) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        cur = exp_q.pop_front();
      end
    end else begin
      cur.rd = m_rd;
      cur.wr = m_wr;
    end
    chk("mon_rdata", sram_rdata, cur.rdata);
    chk("mon_err", {31'h0, sram_err}, {31'h0, cur.err});
    chk("mon_rd_cnt", rd_cnt, cur.rd);
    chk("mon_wr_cnt", wr_cnt, cur.wr);
  end

  initial begin
    logic [31:0] a, w2, w1;
    resetn = 1'b1;
    sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    #1 assert_rst();

    // Reset with a write held on the bus: nothing may happen.
    sram_en = 1'b1; sram_wen = 4'hf; sram_addr = BASE; sram_wdata = 32'hdeadbeef;
    repeat (3) @(negedge clk);
    chk("rst_rdata", sram_rdata, 32'h0);
    chk("rst_rd_cnt", rd_cnt, 32'h0);
    chk("rst_wr_cnt", wr_cnt, 32'h0);
    release_rst();

    // Preload the words used below.
    for (int k = 0; k < 16; k++) req(4'hf, BASE + 32'(4 * k), $urandom);
    req(4'hf, LAST, $urandom);
    idle();

    // Array survives a reset during which a write is presented.
    assert_rst();
    sram_en = 1'b1; sram_wen = 4'hf; sram_addr = BASE; sram_wdata = 32'hdeadbeef;
    repeat (3) @(negedge clk);
    release_rst();
    w1 = mem_m[0];
    req(4'h0, BASE, 32'h0);
    idle();
    chk("preload_kept", sram_rdata, w1);

    // Fresh counters for the directed byte-lane test.
    assert_rst();
    repeat (2) @(negedge clk);
    release_rst();
    req(4'hf, BASE + 32'h10, 32'h11223344);
    req(4'b0101, BASE + 32'h10, 32'haabbccdd);
    req(4'h0, BASE + 32'h10, 32'h0);
    idle();
    chk("lane_merge", sram_rdata, 32'h11bb33dd);
    chk("lane_wr_cnt", wr_cnt, 32'd2);
    chk("lane_rd_cnt", rd_cnt, 32'd1);

    // Read-first.
    req(4'hf, BASE + 32'h10, 32'h11223344);
    idle();
    req(4'hf, BASE + 32'h10, 32'h55667788);
    idle();
    chk("read_first", sram_rdata, 32'h11223344);

    // Window boundaries.
    req(4'h0, 32'h1bfffffc, 32'h0);
    idle();
    chk("below_err", {31'h0, sram_err}, 32'd1);
    chk("below_rdata", sram_rdata, 32'h0);
    req(4'h0, BASE + 32'(WIN), 32'h0);
    idle();
    chk("above_err", {31'h0, sram_err}, 32'd1);
    req(4'h0, LAST, 32'h0);
    idle();
    chk("last_err", {31'h0, sram_err}, 32'd0);
    w1 = mem_m[0];
    req(4'hf, BASE + 32'(WIN), 32'hcafef00d);
    req(4'h0, BASE, 32'h0);
    idle();
    chk("oow_write_ignored", sram_rdata, w1);

    // Pipelined reads, hold across idle, ignored low address bits.
    req(4'h0, BASE, 32'h0);
    req(4'h0, BASE + 32'h4, 32'h0);
    req(4'h0, BASE + 32'h8, 32'h0);
    w2 = mem_m[2];
    repeat (5) idle();
    chk("hold_word2", sram_rdata, w2);
    w1 = mem_m[1];
    req(4'h0, BASE + 32'h6, 32'h0);
    idle();
    chk("unaligned_word1", sram_rdata, w1);

    // Async reset dropped between edges in the middle of a read burst.
    req(4'h0, BASE + 32'h4, 32'h0);
    req(4'h0, BASE + 32'h8, 32'h0);
    #2 assert_rst();
    #1;
    chk("async_rdata", sram_rdata, 32'h0);
    chk("async_rd_cnt", rd_cnt, 32'h0);
    @(negedge clk);
    release_rst();
    req(4'h0, BASE + 32'hc, 32'h0);
    idle();
    chk("restart_rd_cnt", rd_cnt, 32'd1);

    // Randomised traffic over in-window, below-base and above-window addresses.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: a = BASE - 32'(4 * $urandom_range(1, 4));
        1: a = BASE + 32'(WIN) + 32'(4 * $urandom_range(0, 15));
        2: a = LAST;
        default: a = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) idle();
      else req(($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), a, $urandom);
    end
    idle();
    idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
